// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_seq_state_t;

  // Width able to hold 0..max_val-1, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for quasi-static signals entering the local clock domain.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= '0;
      r_q    <= '0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Pulses the rPLL reset, waits for lock with timeout and retries, qualifies
// lock stability and only then releases the pixel-domain reset.
//
//   state     | meaning
//   RST_PLL   | pll_reset asserted for RESET_CYCLES
//   WAIT_LOCK | waiting for synchronised lock, bounded by LOCK_TIMEOUT_CYCLES
//   STABLE    | lock must hold for LOCK_STABLE_CYCLES consecutive cycles
//   RUN       | downstream reset released, watching for lock loss
//   FAIL      | retries exhausted, left only by rst or relock
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES        = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                                i_clkin,
  input  logic                                i_rst,
  input  logic                                i_pll_lock,
  input  logic                                i_relock,
  output logic                                o_pll_reset,
  output logic                                o_sys_rst,
  output logic                                o_locked,
  output logic                                o_fail,
  output logic [cnt_width(MAX_RETRIES+1)-1:0] o_retry_cnt
);

  localparam int CW = cnt_width(max3(RESET_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES));
  localparam int RW = cnt_width(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  pll_seq_state_t r_state;
  pll_seq_state_t w_next;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_cnt_inc;
  logic [RW-1:0]  r_retry_cnt;
  logic           w_lock_s;
  logic           w_entry;
  logic           w_timeout_retry;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .i_clk (i_clkin),
    .i_rst (i_rst),
    .i_d   (i_pll_lock),
    .o_q   (w_lock_s)
  );

  always_comb begin
    w_next          = r_state;
    w_timeout_retry = 1'b0;
    w_cnt_inc       = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);
    case (r_state)
      RST_PLL:   if (r_cnt == RESET_LAST) w_next = WAIT_LOCK;
      WAIT_LOCK: begin
        // Lock seen on the timeout cycle still counts as a lock.
        if (w_lock_s) begin
          w_next = STABLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          if (r_retry_cnt == RETRY_MAX) begin
            w_next = FAIL;
          end else begin
            w_next          = RST_PLL;
            w_timeout_retry = 1'b1;
          end
        end
      end
      STABLE: begin
        if (!w_lock_s)                  w_next = WAIT_LOCK;
        else if (r_cnt == STABLE_LAST)  w_next = RUN;
      end
      RUN:     if (!w_lock_s) w_next = RST_PLL;
      FAIL:    w_next = FAIL;
      default: w_next = RST_PLL;
    endcase
    if (i_relock) begin
      w_next          = RST_PLL;
      w_timeout_retry = 1'b0;
    end
    // A relock while already in RST_PLL must still restart the pulse width.
    w_entry = (w_next != r_state) || i_relock;
  end

  always_ff @(posedge i_clkin) begin
    if (i_rst) begin
      r_state     <= RST_PLL;
      r_cnt       <= '0;
      r_retry_cnt <= '0;
      o_pll_reset <= 1'b1;
      o_sys_rst   <= 1'b1;
      o_locked    <= 1'b0;
      o_fail      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_entry ? '0 : w_cnt_inc;
      if (i_relock || (w_next == RUN && r_state != RUN)) begin
        r_retry_cnt <= '0;
      end else if (w_timeout_retry && r_retry_cnt != RETRY_MAX) begin
        r_retry_cnt <= r_retry_cnt + RW'(1);
      end
      o_pll_reset <= (w_next == RST_PLL);
      o_sys_rst   <= (w_next != RUN);
      o_locked    <= (w_next == RUN);
      o_fail      <= (w_next == FAIL);
    end
  end

  assign o_retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters.
module tb_pll_lock_sequencer;
  import pll_seq_pkg::*;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic       relock;
  logic       pll_reset;
  logic       sys_rst;
  logic       locked;
  logic       fail;
  logic [1:0] retry_cnt;

  int checks;
  int failures;

  pll_lock_sequencer #(
    .RESET_CYCLES        (4),
    .LOCK_STABLE_CYCLES  (8),
    .LOCK_TIMEOUT_CYCLES (32),
    .MAX_RETRIES         (2)
  ) dut (
    .i_clkin     (clk),
    .i_rst       (rst),
    .i_pll_lock  (pll_lock),
    .i_relock    (relock),
    .o_pll_reset (pll_reset),
    .o_sys_rst   (sys_rst),
    .o_locked    (locked),
    .o_fail      (fail),
    .o_retry_cnt (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic go_run();
    int n;
    do_reset();
    repeat (4) tick();
    pll_lock = 1'b1;
    n = 0;
    while (sys_rst && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (sys_rst !== 1'b0) begin
      failures++;
      $display("FAIL go_run_release: sys_rst=%0b required 0", sys_rst);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pll_lock = 1'b0; relock = 1'b0;
    tick(); tick();
    checks++;
    if ({pll_reset, sys_rst, locked, fail, retry_cnt} !== 6'b110000) begin
      failures++;
      $display("FAIL reset_values: pr/sr/lk/fl/rc=%b required 110000",
               {pll_reset, sys_rst, locked, fail, retry_cnt});
    end
    checks++;
    if (dut.r_state !== RST_PLL) begin
      failures++;
      $display("FAIL reset_state: state=%0d required %0d", dut.r_state, RST_PLL);
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    int n;
    do_reset();
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pll_reset) n++;
      else break;
    end
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL nominal_reset_width: width=%0d required 4", n);
    end
    repeat (9) tick();
    pll_lock = 1'b1;
    n = 0;
    while (sys_rst && n < 60) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 11) begin
      failures++;
      $display("FAIL nominal_release_latency: cycles=%0d required 11", n);
    end
    checks++;
    if ({locked, retry_cnt, pll_reset, fail} !== 5'b10000) begin
      failures++;
      $display("FAIL nominal_run_outputs: lk/rc/pr/fl=%b required 10000",
               {locked, retry_cnt, pll_reset, fail});
    end
  endtask

  task automatic test_glitch();
    int first_low;
    do_reset();
    repeat (4) tick();
    pll_lock = 1'b1;
    first_low = -1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t == 5) pll_lock = 1'b0;
      if (t == 6) pll_lock = 1'b1;
      if (t == 8) begin
        checks++;
        if (dut.r_state !== WAIT_LOCK || sys_rst !== 1'b1) begin
          failures++;
          $display("FAIL glitch_back_to_wait: state=%0d sys_rst=%0b required %0d/1",
                   dut.r_state, sys_rst, WAIT_LOCK);
        end
      end
      if (!sys_rst && first_low < 0) first_low = t;
    end
    checks++;
    if (first_low !== 17) begin
      failures++;
      $display("FAIL glitch_release_cycle: cycle=%0d required 17", first_low);
    end
  endtask

  task automatic test_timeout_fail();
    int   highs, pulses, fail_edge, start1, start2;
    logic prev;
    logic [1:0] r1, r2;
    pll_lock = 1'b0;
    do_reset();
    prev = pll_reset; highs = pll_reset ? 1 : 0; pulses = 1;
    fail_edge = -1; start1 = -1; start2 = -1; r1 = 2'd3; r2 = 2'd3;
    for (int e = 1; e <= 115; e++) begin
      tick();
      if (pll_reset) highs++;
      if (pll_reset && !prev) begin
        pulses++;
        if (pulses == 2) begin start1 = e; r1 = retry_cnt; end
        if (pulses == 3) begin start2 = e; r2 = retry_cnt; end
      end
      if (fail && fail_edge < 0) fail_edge = e;
      prev = pll_reset;
    end
    checks++;
    if (pulses !== 3 || highs !== 12) begin
      failures++;
      $display("FAIL timeout_pulses: pulses=%0d high_cycles=%0d required 3/12", pulses, highs);
    end
    checks++;
    if (start1 !== 36 || r1 !== 2'd1) begin
      failures++;
      $display("FAIL timeout_retry1: edge=%0d retry=%0d required 36/1", start1, r1);
    end
    checks++;
    if (start2 !== 72 || r2 !== 2'd2) begin
      failures++;
      $display("FAIL timeout_retry2: edge=%0d retry=%0d required 72/2", start2, r2);
    end
    checks++;
    if (fail_edge !== 108) begin
      failures++;
      $display("FAIL timeout_fail_edge: edge=%0d required 108", fail_edge);
    end
    checks++;
    if ({fail, pll_reset, sys_rst, locked, retry_cnt} !== 6'b101010) begin
      failures++;
      $display("FAIL fail_outputs: fl/pr/sr/lk/rc=%b required 101010",
               {fail, pll_reset, sys_rst, locked, retry_cnt});
    end
  endtask

  task automatic test_lock_loss();
    int n, n_hi;
    go_run();
    pll_lock = 1'b0;
    tick(); tick();
    checks++;
    if (sys_rst !== 1'b0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL loss_too_early: sys_rst=%0b locked=%0b required 0/1", sys_rst, locked);
    end
    tick();
    checks++;
    if ({sys_rst, locked, pll_reset} !== 3'b101) begin
      failures++;
      $display("FAIL loss_outputs: sr/lk/pr=%b required 101", {sys_rst, locked, pll_reset});
    end
    pll_lock = 1'b1;
    n = 0; n_hi = 1;
    while (sys_rst && n < 60) begin
      tick();
      n++;
      if (pll_reset) n_hi++;
    end
    checks++;
    if (n_hi !== 4 || n !== 13 || locked !== 1'b1) begin
      failures++;
      $display("FAIL loss_recover: reset_width=%0d release=%0d locked=%0b required 4/13/1",
               n_hi, n, locked);
    end
  endtask

  task automatic test_relock();
    int n;
    // Entered straight from FAIL left by test_timeout_fail.
    relock = 1'b1; tick(); relock = 1'b0;
    checks++;
    if ({pll_reset, sys_rst, fail, retry_cnt} !== 5'b11000) begin
      failures++;
      $display("FAIL relock_from_fail: pr/sr/fl/rc=%b required 11000",
               {pll_reset, sys_rst, fail, retry_cnt});
    end
    pll_lock = 1'b0;
    do_reset();
    repeat (40) tick();
    checks++;
    if (retry_cnt !== 2'd1) begin
      failures++;
      $display("FAIL relock_pre_retry: retry=%0d required 1", retry_cnt);
    end
    relock = 1'b1; tick(); relock = 1'b0;
    checks++;
    if (retry_cnt !== 2'd0 || pll_reset !== 1'b1) begin
      failures++;
      $display("FAIL relock_clears_retry: retry=%0d pll_reset=%0b required 0/1", retry_cnt, pll_reset);
    end
    go_run();
    pll_lock = 1'b0;
    tick(); tick();
    relock = 1'b1; tick(); relock = 1'b0;
    checks++;
    if ({pll_reset, sys_rst, locked, fail, retry_cnt} !== 6'b110000) begin
      failures++;
      $display("FAIL relock_with_loss: pr/sr/lk/fl/rc=%b required 110000",
               {pll_reset, sys_rst, locked, fail, retry_cnt});
    end
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pll_reset) n++;
      else break;
    end
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL relock_pulse_width: width=%0d required 4", n);
    end
  endtask

  task automatic test_rst_mid();
    pll_lock = 1'b0;
    do_reset();
    repeat (4) tick();
    pll_lock = 1'b1;
    repeat (4) tick();
    checks++;
    if (dut.r_state !== STABLE) begin
      failures++;
      $display("FAIL rst_pre_stable: state=%0d required %0d", dut.r_state, STABLE);
    end
    do_reset();
    checks++;
    if ({pll_reset, sys_rst, locked, fail, retry_cnt} !== 6'b110000 || dut.r_state !== RST_PLL) begin
      failures++;
      $display("FAIL rst_in_stable: pr/sr/lk/fl/rc=%b state=%0d required 110000/%0d",
               {pll_reset, sys_rst, locked, fail, retry_cnt}, dut.r_state, RST_PLL);
    end
    pll_lock = 1'b0;
    do_reset();
    repeat (40) tick();
    checks++;
    if (dut.r_state !== WAIT_LOCK || retry_cnt !== 2'd1) begin
      failures++;
      $display("FAIL rst_pre_wait: state=%0d retry=%0d required %0d/1", dut.r_state, retry_cnt, WAIT_LOCK);
    end
    do_reset();
    checks++;
    if ({pll_reset, sys_rst, locked, fail, retry_cnt} !== 6'b110000 || dut.r_state !== RST_PLL) begin
      failures++;
      $display("FAIL rst_in_wait: pr/sr/lk/fl/rc=%b state=%0d required 110000/%0d",
               {pll_reset, sys_rst, locked, fail, retry_cnt}, dut.r_state, RST_PLL);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_nominal();
    test_glitch();
    test_timeout_fail();
    test_relock();
    test_lock_loss();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
